// File: rtl/rvv_lsu_uop_sequencer.sv
// Vector LSU uop sequencer: accepts one load/store instruction at a time and
// walks its uop index, issuing up to NUM_DE_UOP uops per cycle as the uop queue allows.
module rvv_lsu_uop_sequencer #(
  parameter int NUM_DE_UOP      = 2,
  parameter int UOP_INDEX_WIDTH = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            inst_valid,
  output logic                            inst_ready,
  input  logic [UOP_INDEX_WIDTH:0]        inst_uop_total,
  input  logic                            inst_illegal,
  input  logic [$clog2(NUM_DE_UOP):0]     uq_free,
  output logic                            de_valid,
  output logic [UOP_INDEX_WIDTH-1:0]      uop_index_remain,
  output logic [NUM_DE_UOP-1:0]           uop_push,
  output logic                            inst_done,
  output logic                            illegal_trap
);

  localparam int IW = UOP_INDEX_WIDTH + 1;
  localparam logic [IW-1:0] MAX_TOTAL = IW'(2 ** UOP_INDEX_WIDTH);
  localparam logic [IW-1:0] DE_MAX    = IW'(NUM_DE_UOP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_TRAP  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   total_q, total_d;

  logic [IW-1:0]   remain;
  logic [IW-1:0]   free_w;
  logic [IW-1:0]   n_issue;
  logic            last_cycle;
  logic            accept;
  logic            inst_bad;

  // Uops issued this cycle: min(decode width, uops left, queue space)
  always_comb begin
    remain  = total_q - idx_q;
    free_w  = IW'(uq_free);
    n_issue = remain;
    if (n_issue > DE_MAX) n_issue = DE_MAX;
    if (n_issue > free_w) n_issue = free_w;
    if (state_q != S_ISSUE) n_issue = '0;
    last_cycle = (state_q == S_ISSUE) && (n_issue != '0) && (idx_q + n_issue == total_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      total_q <= total_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    total_d  = total_q;
    inst_bad = inst_illegal || (inst_uop_total == '0) || (inst_uop_total > MAX_TOTAL);
    accept   = inst_valid && inst_ready;
    if (flush) begin
      state_d = S_IDLE;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        S_ISSUE: begin
          idx_d = idx_q + n_issue;
          if (last_cycle) begin
            state_d = S_IDLE;
            idx_d   = '0;
          end
        end
        S_TRAP:  state_d = S_IDLE;
        default: ;
      endcase
      // A new instruction can land in IDLE or on the last ISSUE cycle
      if (accept) begin
        idx_d = '0;
        if (inst_bad) begin
          state_d = S_TRAP;
        end else begin
          state_d = S_ISSUE;
          total_d = inst_uop_total;
        end
      end
    end
  end

  always_comb begin
    inst_ready       = 1'b0;
    de_valid         = 1'b0;
    uop_push         = '0;
    inst_done        = 1'b0;
    illegal_trap     = 1'b0;
    uop_index_remain = idx_q[UOP_INDEX_WIDTH-1:0];
    unique case (state_q)
      S_IDLE:  inst_ready = !flush;
      S_ISSUE: begin
        de_valid   = 1'b1;
        inst_ready = last_cycle && !flush;
        inst_done  = last_cycle && !flush;
        for (int i = 0; i < NUM_DE_UOP; i++) begin
          uop_push[i] = (IW'(i) < n_issue) && !flush;
        end
      end
      S_TRAP:  illegal_trap = !flush;
      default: ;
    endcase
  end

`ifndef SYNTHESIS
  logic [NUM_DE_UOP:0] push_inc;
  assign push_inc = {1'b0, uop_push} + 1'b1;

  a_push_contig: assert property (@(posedge clk) disable iff (!rst_n)
    (push_inc[NUM_DE_UOP-1:0] & uop_push) == '0);
  a_push_free: assert property (@(posedge clk) disable iff (!rst_n)
    $countones(uop_push) <= int'(uq_free));
  a_done_trap: assert property (@(posedge clk) disable iff (!rst_n)
    !(inst_done && illegal_trap));
  a_idx_bound: assert property (@(posedge clk) disable iff (!rst_n)
    idx_q <= total_q);
`endif

endmodule

// File: doc/rvv_lsu_uop_sequencer.md
Name: rvv_lsu_uop_sequencer

Overview:
- Sequences one vector load/store instruction at a time into the LSU decode datapath. Walks the uop index (0..total-1) across as many cycles as needed.
- Each cycle, issues up to NUM_DE_UOP uops, limited by free uop-queue entries.
- Sits between the instruction buffer (valid/ready) and the LSU decode unit / uop queue. Drives the uop_index_remain base and the per-slot push mask.

Parameters:
- NUM_DE_UOP, 2, max uops decoded and pushed per cycle (1..4)
- UOP_INDEX_WIDTH, 3, width of uop index; max uops per instruction = 2**UOP_INDEX_WIDTH (8)

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous abort of current instruction (trap/redirect)
- inst_valid  input  1  instruction buffer holds an LSU instruction
- inst_ready  output  1  instruction accepted when inst_valid & inst_ready
- inst_uop_total  input  UOP_INDEX_WIDTH+1  uops required by instruction (from EMUL/NF); legal 1..2**UOP_INDEX_WIDTH
- inst_illegal  input  1  decode flagged illegal encoding/vill
- uq_free  input  $clog2(NUM_DE_UOP)+1  free uop-queue entries this cycle (saturated at NUM_DE_UOP)
- de_valid  output  1  decode unit inst_valid
- uop_index_remain  output  UOP_INDEX_WIDTH  index of first uop issued this cycle
- uop_push  output  NUM_DE_UOP  per-slot push into uop queue; always a contiguous low-bit mask
- inst_done  output  1  one-cycle pulse: last uop of instruction pushed
- illegal_trap  output  1  one-cycle pulse: instruction rejected, no uops pushed

Behaviour:
- Reset (rst_n low, async): state=IDLE, idx=0, total=0; inst_ready=1, de_valid=0, uop_push=0, uop_index_remain=0, inst_done=0, illegal_trap=0.
- States: IDLE, ISSUE, TRAP.
- IDLE:
  - inst_ready=1.
  - Accept with inst_illegal=1, or inst_uop_total=0, or inst_uop_total > 2**UOP_INDEX_WIDTH: go to TRAP.
  - Any other accept: latch total, idx=0, go to ISSUE. No uops in the accept cycle (1-cycle latency from accept to first push).
- ISSUE:
  - de_valid=1; uop_index_remain=idx.
  - n = min(NUM_DE_UOP, total-idx, uq_free). uop_push = (1<<n)-1. idx += n.
  - n=0 (uq_free=0): hold idx, uop_push=0, de_valid stays 1.
  - Last cycle (idx+n==total, n>0): inst_done=1 and inst_ready=1 in the same cycle. A back-to-back accept loads the new instruction and stays in ISSUE (or goes to TRAP if illegal); otherwise return to IDLE.
  - inst_ready=0 on all non-last ISSUE cycles.
- TRAP:
  - illegal_trap=1 for exactly one cycle; uop_push=0, de_valid=0, inst_ready=0; next state IDLE.
- flush (synchronous, highest priority after reset):
  - Forces next state IDLE and idx=0.
  - In the flush cycle, uop_push=0, inst_ready=0, inst_done=0, illegal_trap=0.
  - A pending accept in that cycle is not taken.
- Arithmetic: idx is UOP_INDEX_WIDTH+1 bits internally; never wraps, since idx<=total<=2**UOP_INDEX_WIDTH. uop_index_remain outputs the low UOP_INDEX_WIDTH bits of idx.
- All outputs are registered-state decodes. uop_push, inst_done and inst_ready depend combinationally on uq_free and current state; no combinational path from inst_valid to any output.
- Assertions:
  - uop_push is contiguous from bit 0.
  - popcount(uop_push) <= uq_free.
  - inst_done and illegal_trap are never high together.
  - idx never exceeds total.

Test Plan:
- Reset mid-ISSUE (total=8, idx=4), rst_n low -> all outputs go to reset values immediately without waiting for a clock edge; after release, inst_ready=1 and the state is IDLE.
- NUM_DE_UOP=2, uq_free=2, total=5 -> cycles push masks 11,11,01 with uop_index_remain 0,2,4; inst_done on the third cycle; a second instruction (total=1) presented back-to-back is accepted that cycle and pushes 01 with index 0 on the next cycle.
- total=4, uq_free sequence 1,0,2,1 -> masks 01,00,11,01; indices 0,1,1,3; inst_done on the fourth cycle.
- inst_illegal=1 (or total=0) accepted -> next cycle illegal_trap=1, uop_push=0, de_valid=0; the following cycle inst_ready=1.
- total=8, flush asserted after index 4 is pushed -> flush cycle uop_push=0; next cycle IDLE with inst_ready=1; no inst_done.
- total=8, uq_free=0 for 10 cycles then 2 -> idx holds at 0 with de_valid=1; then 4 cycles of mask 11 and inst_done on the last.
